// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network weight path.
//   WEIGHT_W       : width of one Int4 weight
//   loader_state_e : weight_loader FSM states
package nn_pkg;

  localparam int unsigned WEIGHT_W = 4;

  // StLoadLo: waiting for a byte, or writing the low nibble of the held byte.
  // StLoadHi: writing the high nibble of the held byte.
  typedef enum logic [1:0] {
    StIdle,
    StLoadLo,
    StLoadHi,
    StDone
  } loader_state_e;

endpackage

// File: rtl/nibble_unpacker.sv
// Holds one packed weight byte and presents either its low or high nibble.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture byte_i and select its low nibble
//   take_hi_i  : switch the output to the high nibble of the held byte
//   byte_i     : packed byte, weight k in [3:0], weight k+1 in [7:4]
//   nibble_o   : selected nibble (driven only from flops)
module nibble_unpacker
  import nn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  take_hi_i,
  input  logic [2*WEIGHT_W-1:0] byte_i,
  output logic [WEIGHT_W-1:0]   nibble_o
);

  logic [2*WEIGHT_W-1:0] byte_q, byte_d;
  logic                  sel_hi_q, sel_hi_d;

  always_comb begin
    byte_d   = byte_q;
    sel_hi_d = sel_hi_q;
    if (load_i) begin
      byte_d   = byte_i;
      sel_hi_d = 1'b0;
    end else if (take_hi_i) begin
      sel_hi_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q   <= '0;
      sel_hi_q <= 1'b0;
    end else begin
      byte_q   <= byte_d;
      sel_hi_q <= sel_hi_d;
    end
  end

  assign nibble_o = sel_hi_q ? byte_q[2*WEIGHT_W-1:WEIGHT_W] : byte_q[WEIGHT_W-1:0];

endmodule

// File: rtl/weight_loader.sv
// Streams packed Int4 weight bytes into NUM_NEURONS banks of NUM_WEIGHTS weights each.
// Every accepted byte yields two writes (low nibble, then high nibble) on consecutive
// cycles; nibbles may straddle a bank boundary when NUM_WEIGHTS is odd.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a load session (honoured only when idle)
//   in_data/in_valid/in_ready : byte stream handshake
//   wr_en/wr_neuron/wr_addr/wr_data : registered weight-memory write port
//   busy, done          : session active / one-cycle completion pulse
//   checksum            : mod-2^16 sum of accepted bytes
// Optional feature: define WEIGHT_LOADER_CHECKSUM_EN to build the checksum
// accumulator; otherwise checksum is tied to 0.
module weight_loader
  import nn_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 128,
  parameter int unsigned NUM_WEIGHTS = 784,
  localparam int unsigned NeuronW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                wr_en,
  output logic [NeuronW-1:0]  wr_neuron,
  output logic [31:0]         wr_addr,
  output logic [WEIGHT_W-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic [15:0]         checksum
);

  localparam logic [NeuronW-1:0] LastNeuron = NeuronW'(NUM_NEURONS - 1);
  localparam logic [31:0]        LastAddr   = 32'(NUM_WEIGHTS - 1);

  loader_state_e      state_q, state_d;
  logic [NeuronW-1:0] neuron_q, neuron_d;     // bank of the next weight to write
  logic [31:0]        addr_q, addr_d;         // address of the next weight to write
  logic               wr_en_q, wr_en_d;
  logic [NeuronW-1:0] wr_neuron_q, wr_neuron_d;
  logic [31:0]        wr_addr_q, wr_addr_d;
  logic               issue, load, take_hi, clear, wr_final;

  // The write currently on the port is the last weight of the session.
  assign wr_final = wr_en_q && (wr_neuron_q == LastNeuron) && (wr_addr_q == LastAddr);

  always_comb begin
    state_d     = state_q;
    neuron_d    = neuron_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    wr_neuron_d = wr_neuron_q;
    wr_addr_d   = wr_addr_q;
    in_ready    = 1'b0;
    issue       = 1'b0;
    load        = 1'b0;
    take_hi     = 1'b0;
    clear       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StLoadLo;
          neuron_d = '0;
          addr_d   = '0;
          clear    = 1'b1;
        end
      end
      StLoadLo: begin
        if (wr_en_q) begin
          // Low nibble is being written; a final low nibble drops the high one.
          if (wr_final) begin
            state_d = StDone;
          end else begin
            state_d = StLoadHi;
            take_hi = 1'b1;
            issue   = 1'b1;
          end
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            load  = 1'b1;
            issue = 1'b1;
          end
        end
      end
      StLoadHi: begin
        // Accepting here lets the next low nibble follow with no bubble.
        in_ready = !wr_final;
        if (wr_final) begin
          state_d = StDone;
        end else begin
          state_d = StLoadLo;
          if (in_valid) begin
            load  = 1'b1;
            issue = 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (issue) begin
      wr_en_d     = 1'b1;
      wr_neuron_d = neuron_q;
      wr_addr_d   = addr_q;
      if (addr_q == LastAddr) begin
        addr_d   = '0;
        neuron_d = neuron_q + NeuronW'(1);
      end else begin
        addr_d = addr_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      neuron_q    <= '0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_neuron_q <= '0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      neuron_q    <= neuron_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      wr_neuron_q <= wr_neuron_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  nibble_unpacker u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .take_hi_i (take_hi),
    .byte_i    (in_data),
    .nibble_o  (wr_data)
  );

  assign wr_en     = wr_en_q;
  assign wr_neuron = wr_neuron_q;
  assign wr_addr   = wr_addr_q;
  assign busy      = (state_q == StLoadLo) || (state_q == StLoadHi);
  assign done      = (state_q == StDone);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (clear) begin
      checksum_d = '0;
    end else if (load) begin
      checksum_d = checksum_q + 16'(in_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: three instances (2x4, 2x3, 1x1) driven by directed byte
// streams, checked every cycle against a schedule model and against literal tables.
module tb_weight_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start     [3];
  logic        in_valid  [3];
  logic [7:0]  in_data   [3];
  logic        in_ready  [3];
  logic        wr_en     [3];
  logic [0:0]  wr_neuron [3];
  logic [31:0] wr_addr   [3];
  logic [3:0]  wr_data   [3];
  logic        busy      [3];
  logic        done      [3];
  logic [15:0] checksum  [3];

  weight_loader #(.NUM_NEURONS(2), .NUM_WEIGHTS(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_data(in_data[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .wr_en(wr_en[0]),
    .wr_neuron(wr_neuron[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .busy(busy[0]), .done(done[0]), .checksum(checksum[0])
  );
  weight_loader #(.NUM_NEURONS(2), .NUM_WEIGHTS(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_data(in_data[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .wr_en(wr_en[1]),
    .wr_neuron(wr_neuron[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .busy(busy[1]), .done(done[1]), .checksum(checksum[1])
  );
  weight_loader #(.NUM_NEURONS(1), .NUM_WEIGHTS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .in_data(in_data[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .wr_en(wr_en[2]),
    .wr_neuron(wr_neuron[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]),
    .busy(busy[2]), .done(done[2]), .checksum(checksum[2])
  );

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam bit CsEn = 1'b1;
`else
  localparam bit CsEn = 1'b0;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned done_cyc [3];

  typedef struct {
    int unsigned dut, cyc, n, a, d;
  } wr_t;
  wr_t log_q[$];

  // Hand-computed write tables: 2 banks x 4 weights, and 2 banks x 3 weights.
  int unsigned t4_n [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int unsigned t4_a [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int unsigned t4_d [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int unsigned t3_n [6] = '{0, 0, 0, 1, 1, 1};
  int unsigned t3_a [6] = '{0, 1, 2, 0, 1, 2};
  int unsigned t3_d [6] = '{1, 2, 3, 4, 5, 6};

  // Model: a session is a flat weight index g over NN*NW weights; each accepted byte
  // schedules weight g (low nibble) next cycle and g+1 (high nibble) the cycle after.
  bit          m_act   [3];
  bit          m_done  [3];
  int unsigned m_g     [3];
  bit          m_cur_v [3];
  int unsigned m_cur_g [3];
  int unsigned m_cur_d [3];
  bit          m_nxt_v [3];
  int unsigned m_nxt_g [3];
  int unsigned m_nxt_d [3];
  logic [15:0] m_csum  [3];
  int unsigned m_wr_cnt[3];

  function automatic int unsigned nw_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 3 : 1;
  endfunction

  function automatic int unsigned total_of(input int i);
    return (i == 2) ? 1 : 2 * nw_of(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        bit          fin, rdy;
        int unsigned lim;
        if (!rst_n) begin
          m_act[i] = 0; m_done[i] = 0; m_g[i] = 0; m_cur_v[i] = 0; m_nxt_v[i] = 0;
          m_csum[i] = '0;
        end
        lim = total_of(i);
        fin = m_cur_v[i] && (m_cur_g[i] == lim - 1);
        rdy = m_act[i] && !m_nxt_v[i] && !fin;
        chk($sformatf("dut%0d wr_en", i), 32'(wr_en[i]), 32'(m_cur_v[i]));
        chk($sformatf("dut%0d busy", i), 32'(busy[i]), 32'(m_act[i]));
        chk($sformatf("dut%0d done", i), 32'(done[i]), 32'(m_done[i]));
        chk($sformatf("dut%0d in_ready", i), 32'(in_ready[i]), 32'(rdy));
        chk($sformatf("dut%0d checksum", i), 32'(checksum[i]), CsEn ? 32'(m_csum[i]) : 32'd0);
        if (m_cur_v[i]) begin
          m_wr_cnt[i]++;
          chk($sformatf("dut%0d wr_neuron", i), 32'(wr_neuron[i]), m_cur_g[i] / nw_of(i));
          chk($sformatf("dut%0d wr_addr", i), wr_addr[i], m_cur_g[i] % nw_of(i));
          chk($sformatf("dut%0d wr_data", i), 32'(wr_data[i]), m_cur_d[i]);
        end
        if (wr_en[i]) begin
          log_q.push_back('{dut: i, cyc: cyc, n: 32'(wr_neuron[i]), a: wr_addr[i],
                            d: 32'(wr_data[i])});
        end
        if (done[i]) done_cyc[i] = cyc;
        if (rst_n) begin
          bit          was_done;
          was_done   = m_done[i];
          m_cur_v[i] = m_nxt_v[i]; m_cur_g[i] = m_nxt_g[i]; m_cur_d[i] = m_nxt_d[i];
          m_nxt_v[i] = 0;
          m_done[i]  = 0;
          if (was_done) begin
            // back to idle; start ignored in the done cycle
          end else if (!m_act[i]) begin
            if (start[i]) begin
              m_act[i] = 1; m_g[i] = 0; m_csum[i] = '0;
            end
          end else if (fin) begin
            m_act[i] = 0; m_done[i] = 1; m_cur_v[i] = 0;
          end else if (rdy && in_valid[i]) begin
            m_csum[i]  = m_csum[i] + 16'(in_data[i]);
            m_cur_v[i] = 1; m_cur_g[i] = m_g[i]; m_cur_d[i] = 32'(in_data[i][3:0]);
            m_g[i]++;
            if (m_g[i] < lim) begin
              m_nxt_v[i] = 1; m_nxt_g[i] = m_g[i]; m_nxt_d[i] = 32'(in_data[i][7:4]);
              m_g[i]++;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [7:0] b);
    bit got = 0;
    in_valid[i] = 1'b1;
    in_data[i]  = b;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = in_ready[i];
      tick();
    end
    in_valid[i] = 1'b0;
    chk($sformatf("dut%0d byte 0x%0h accepted", i, b), 32'(got), 32'd1);
  endtask

  task automatic wait_done(input int i);
    bit seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = done[i];
    end
    chk($sformatf("dut%0d done seen", i), 32'(seen), 32'd1);
    tick();
  endtask

  task automatic clear_log();
    log_q.delete();
    for (int i = 0; i < 3; i++) m_wr_cnt[i] = 0;
  endtask

  // sel 4: 2x4 table, sel 3: 2x3 table.
  task automatic check_log(input string tag, input int dut, input int sel, input int n_exp);
    chk({tag, " write count"}, log_q.size(), n_exp);
    for (int k = 0; k < n_exp && k < log_q.size(); k++) begin
      chk($sformatf("%s w%0d dut", tag, k), log_q[k].dut, dut);
      chk($sformatf("%s w%0d neuron", tag, k), log_q[k].n, (sel == 4) ? t4_n[k] : t3_n[k]);
      chk($sformatf("%s w%0d addr", tag, k), log_q[k].a, (sel == 4) ? t4_a[k] : t3_a[k]);
      chk($sformatf("%s w%0d data", tag, k), log_q[k].d, (sel == 4) ? t4_d[k] : t3_d[k]);
    end
  endtask

  logic [7:0] bytes4 [4] = '{8'h21, 8'h43, 8'h65, 8'h87};

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = 8'h00; done_cyc[i] = 0;
    end
    repeat (3) tick();
    chk("reset wr_en", 32'(wr_en[0]), 32'd0);
    chk("reset busy", 32'(busy[0]), 32'd0);
    chk("reset in_ready", 32'(in_ready[0]), 32'd0);
    chk("reset wr_addr", wr_addr[0], 32'd0);
    chk("reset wr_neuron", 32'(wr_neuron[0]), 32'd0);
    chk("reset wr_data", 32'(wr_data[0]), 32'd0);
    chk("reset checksum", 32'(checksum[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back bytes: eight writes on consecutive cycles.
    clear_log();
    pulse_start(0);
    for (int k = 0; k < 4; k++) send(0, bytes4[k]);
    wait_done(0);
    tick();
    check_log("s1", 0, 4, 8);
    for (int k = 1; k < 8 && k < log_q.size(); k++)
      chk($sformatf("s1 w%0d consecutive", k), log_q[k].cyc, log_q[0].cyc + k);
    if (log_q.size() == 8) chk("s1 done timing", done_cyc[0], log_q[7].cyc + 1);
    chk("s1 checksum", 32'(checksum[0]), CsEn ? 32'h0150 : 32'h0);
    chk("s1 model writes", m_wr_cnt[0], 32'd8);

    // in_valid toggling: same writes, gaps between byte pairs.
    clear_log();
    pulse_start(0);
    for (int k = 0; k < 4; k++) begin
      send(0, bytes4[k]);
      tick();
      tick();
    end
    wait_done(0);
    check_log("s2", 0, 4, 8);
    if (log_q.size() == 8) begin
      chk("s2 pair back-to-back", log_q[1].cyc, log_q[0].cyc + 1);
      chk("s2 gap present", 32'(log_q[2].cyc > log_q[1].cyc + 1), 32'd1);
    end

    // Odd bank size: the second byte straddles banks, no seventh write.
    clear_log();
    pulse_start(1);
    for (int k = 0; k < 3; k++) send(1, bytes4[k]);
    wait_done(1);
    repeat (4) tick();
    check_log("s3", 1, 3, 6);
    chk("s3 model writes", m_wr_cnt[1], 32'd6);

    // start pulsed mid-session is ignored.
    clear_log();
    pulse_start(0);
    send(0, 8'h21);
    send(0, 8'h43);
    pulse_start(0);
    send(0, 8'h65);
    send(0, 8'h87);
    wait_done(0);
    check_log("s4", 0, 4, 8);

    // Reset after three writes abandons the session.
    clear_log();
    pulse_start(0);
    send(0, 8'h21);
    send(0, 8'h43);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s5 writes before reset", log_q.size(), 32'd3);
    chk("s5 reset wr_en", 32'(wr_en[0]), 32'd0);
    chk("s5 reset busy", 32'(busy[0]), 32'd0);
    chk("s5 reset wr_addr", wr_addr[0], 32'd0);
    chk("s5 reset checksum", 32'(checksum[0]), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    pulse_start(0);
    send(0, 8'h65);
    repeat (3) tick();
    chk("s5 restart write count", log_q.size(), 32'd2);
    if (log_q.size() >= 1) begin
      chk("s5 restart neuron", log_q[0].n, 32'd0);
      chk("s5 restart addr", log_q[0].a, 32'd0);
      chk("s5 restart data", log_q[0].d, 32'd5);
    end
    chk("s5 checksum", 32'(checksum[0]), CsEn ? 32'h0065 : 32'h0);

    // Single-weight session: low nibble written, high nibble dropped.
    clear_log();
    pulse_start(2);
    send(2, 8'hF7);
    wait_done(2);
    repeat (3) tick();
    chk("s6 write count", log_q.size(), 32'd1);
    if (log_q.size() >= 1) begin
      chk("s6 dut", log_q[0].dut, 32'd2);
      chk("s6 neuron", log_q[0].n, 32'd0);
      chk("s6 addr", log_q[0].a, 32'd0);
      chk("s6 data", log_q[0].d, 32'd7);
      chk("s6 done timing", done_cyc[2], log_q[0].cyc + 1);
    end
    chk("s6 checksum", 32'(checksum[2]), CsEn ? 32'h00F7 : 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
